// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver: filtered line sampling, frame checking, E0/F0
// prefix folding and a first-word-fall-through event FIFO.
module ps2_scan_fifo #(
    parameter int FILTER_LEN     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ps2_clk_in,
    input  logic                          ps2_dat_in,
    input  logic                          rd_en,
    output logic [9:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]            ck_sync_q, dt_sync_q;
    logic [FILTER_LEN-1:0] ck_sh_q, dt_sh_q;
    logic                  ck_f_q, dt_f_q, ck_prev_q;
    logic                  fall;

    // Lines idle high, so every conditioning stage resets to 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ck_sync_q <= '1;
            dt_sync_q <= '1;
            ck_sh_q   <= '1;
            dt_sh_q   <= '1;
            ck_f_q    <= 1'b1;
            dt_f_q    <= 1'b1;
            ck_prev_q <= 1'b1;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2_clk_in};
            dt_sync_q <= {dt_sync_q[0], ps2_dat_in};
            ck_sh_q   <= {ck_sh_q[FILTER_LEN-2:0], ck_sync_q[1]};
            dt_sh_q   <= {dt_sh_q[FILTER_LEN-2:0], dt_sync_q[1]};
            if (&ck_sh_q)
                ck_f_q <= 1'b1;
            else if (~|ck_sh_q)
                ck_f_q <= 1'b0;
            if (&dt_sh_q)
                dt_f_q <= 1'b1;
            else if (~|dt_sh_q)
                dt_f_q <= 1'b0;
            ck_prev_q <= ck_f_q;
        end
    end

    assign fall = ck_prev_q & ~ck_f_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          done_q, done_d;
    logic [7:0]    byte_q, byte_d;
    logic          perr_ev, ferr_ev;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        timer_d = timer_q;
        done_d  = 1'b0;
        byte_d  = byte_q;
        perr_ev = 1'b0;
        ferr_ev = 1'b0;
        if (state_q == S_IDLE || fall)
            timer_d = '0;
        else if (timer_q != TMAX)
            timer_d = timer_q + 1'b1;
        if (state_q != S_IDLE && timer_q == TMAX) begin
            state_d = S_IDLE;
            ferr_ev = 1'b1;
            timer_d = '0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dt_f_q) begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                    end
                end
                S_DATA: begin
                    shift_d = {dt_f_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7)
                        state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dt_f_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!dt_f_q)
                        ferr_ev = 1'b1;
                    else if (!(^{shift_q, par_q}))
                        perr_ev = 1'b1;
                    else begin
                        done_d = 1'b1;
                        byte_d = shift_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            timer_q <= '0;
            done_q  <= 1'b0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            byte_q  <= byte_d;
        end
    end

    logic          ext_q, ext_d, brk_q, brk_d;
    logic          push_req, push, pop, full, ovf_ev;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          perr_q, ferr_q, ovf_q;

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        push_req = 1'b0;
        if (done_q) begin
            if (byte_q == 8'hE0)
                ext_d = 1'b1;
            else if (byte_q == 8'hF0)
                brk_d = 1'b1;
            else begin
                push_req = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    // A full FIFO still accepts a push when the same cycle pops.
    assign full    = (count_q == FULL);
    assign pop     = rd_en && (count_q != '0);
    assign push    = push_req && (!full || pop);
    assign ovf_ev  = push_req && full && !pop;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            count_q  <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            perr_q <= perr_ev | (perr_q & ~err_clr);
            ferr_q <= ferr_ev | (ferr_q & ~err_clr);
            ovf_q  <= ovf_ev | (ovf_q & ~err_clr);
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem_q[wr_ptr_q] <= {ext_q, brk_q, byte_q};
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : 10'h000;
    assign fifo_count = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Randomised scoreboard bench for ps2_scan_fifo: byte-level reference model
// feeds an expectation queue that a free-running reader checks.
module tb_ps2_scan_fifo;

    localparam int FL   = 16;
    localparam int FD   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 30;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk_in, ps2_dat_in;
    logic       rd_en;
    logic       err_clr;
    logic [9:0] rd_data;
    logic       rd_valid;
    logic [3:0] fifo_count;
    logic       parity_err, frame_err, overflow;

    ps2_scan_fifo #(
        .FILTER_LEN(FL),
        .FIFO_DEPTH(FD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ps2_clk_in(ps2_clk_in),
        .ps2_dat_in(ps2_dat_in),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .fifo_count(fifo_count),
        .err_clr(err_clr),
        .parity_err(parity_err),
        .frame_err(frame_err),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [9:0] exp_q[$];
    bit         m_ext, m_brk, m_perr, m_ferr, m_ovf;
    bit         reader_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clock);
    endtask

    // Reference: what a well-formed or broken frame means at byte level.
    task automatic model_frame(logic [7:0] b, bit bad_par, bit bad_stop);
        if (bad_stop)
            m_ferr = 1'b1;
        else if (bad_par)
            m_perr = 1'b1;
        else if (b == 8'hE0)
            m_ext = 1'b1;
        else if (b == 8'hF0)
            m_brk = 1'b1;
        else begin
            if (exp_q.size() < FD)
                exp_q.push_back({m_ext, m_brk, b});
            else
                m_ovf = 1'b1;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bit(bit v);
        ps2_dat_in = v;
        wait_cyc(HALF);
        ps2_clk_in = 1'b0;
        wait_cyc(HALF);
        ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(logic [7:0] b, bit bad_par, bit bad_stop);
        bit par;
        model_frame(b, bad_par, bad_stop);
        par = ~(^b) ^ bad_par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(b[i]);
        send_bit(par);
        send_bit(!bad_stop);
        ps2_dat_in = 1'b1;
        wait_cyc(3 * HALF);
    endtask

    task automatic check_flags(string tag);
        @(negedge clock);
        check({tag, " parity_err"}, parity_err, m_perr);
        check({tag, " frame_err"}, frame_err, m_ferr);
        check({tag, " overflow"}, overflow, m_ovf);
    endtask

    task automatic clear_flags();
        @(negedge clock);
        err_clr = 1'b1;
        @(negedge clock);
        err_clr = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic drain(string tag);
        bit done;
        done = 1'b0;
        reader_en = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !rd_valid)
                done = 1'b1;
        end
        reader_en = 1'b0;
        wait_cyc(2);
        @(negedge clock);
        check({tag, " drained"}, done, 1);
        check({tag, " count empty"}, fifo_count, 0);
        check({tag, " rd_data empty"}, rd_data, 0);
    endtask

    // Reader/monitor: pops at random, including pops on an empty FIFO.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clock);
            if (reader_en && !reset && $urandom_range(1, 0) == 1) begin
                rd_en = 1'b1;
                if (rd_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected entry: got %0h, expected none",
                                 rd_data);
                    end else
                        check("rd_data", rd_data, exp_q.pop_front());
                end else
                    check("rd_data while empty", rd_data, 0);
            end else
                rd_en = 1'b0;
        end
    end

    initial begin
        bit         seen;
        logic [7:0] b;
        int         r;

        reset      = 1'b1;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        err_clr    = 1'b0;
        wait_cyc(5);
        #1;
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 0);
        check("reset count", fifo_count, 0);
        check("reset flags", {parity_err, frame_err, overflow}, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_cyc(40);

        send_frame(8'h1C, 0, 0);
        @(negedge clock);
        check("1C rd_valid", rd_valid, 1);
        check("1C rd_data", rd_data, 10'h01C);
        check("1C count", fifo_count, 1);
        drain("1C");

        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h6B, 0, 0);
        @(negedge clock);
        check("E0F0 6B count", fifo_count, 1);
        check("E0F0 6B rd_data", rd_data, 10'h36B);
        send_frame(8'h1C, 0, 0);
        drain("prefix");

        send_frame(8'h1C, 1, 0);
        check("bad parity no push", fifo_count, 0);
        check_flags("parity");
        clear_flags();
        check_flags("parity cleared");

        @(negedge clock);
        err_clr = 1'b1;
        seen = 1'b0;
        fork
            send_frame(8'h1C, 1, 0);
            for (int i = 0; i < 2000 && !seen; i++) begin
                @(negedge clock);
                if (parity_err) begin
                    seen = 1'b1;
                    err_clr = 1'b0;
                end
            end
        join
        err_clr = 1'b0;
        check("event beats err_clr", seen, 1);
        check_flags("event beats err_clr");
        clear_flags();

        for (int i = 1; i <= 9; i++)
            send_frame(8'(i), 0, 0);
        @(negedge clock);
        check("overflow count", fifo_count, 8);
        check("overflow head", rd_data, 10'h001);
        check_flags("overflow");
        drain("overflow");
        clear_flags();

        @(negedge clock);
        ps2_dat_in = 1'b0;
        wait_cyc(60);
        ps2_clk_in = 1'b0;
        wait_cyc(3);
        ps2_clk_in = 1'b1;
        wait_cyc(60);
        ps2_dat_in = 1'b1;
        wait_cyc(60);
        send_frame(8'h29, 0, 0);
        @(negedge clock);
        check("after glitch rd_data", rd_data, 10'h029);
        check_flags("glitch");
        drain("glitch");

        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(i[0]);
        ps2_dat_in = 1'b1;
        m_ferr = 1'b1;
        wait_cyc(TO + 200);
        check_flags("timeout");
        clear_flags();
        send_frame(8'h29, 0, 0);
        @(negedge clock);
        check("after timeout rd_data", rd_data, 10'h029);
        drain("timeout");

        send_frame(8'h1C, 0, 0);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 1, 0);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++)
            send_bit(1'b1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset rd_valid", rd_valid, 0);
        check("midreset rd_data", rd_data, 0);
        check("midreset count", fifo_count, 0);
        check("midreset flags", {parity_err, frame_err, overflow}, 0);
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_perr = 0; m_ferr = 0; m_ovf = 0;
        ps2_clk_in = 1'b1;
        ps2_dat_in = 1'b1;
        wait_cyc(5);
        @(negedge clock);
        reset = 1'b0;
        wait_cyc(40);
        send_frame(8'h5A, 0, 0);
        @(negedge clock);
        check("after reset rd_data", rd_data, 10'h05A);
        drain("reset");

        reader_en = 1'b1;
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(9, 0));
            if (r == 0)
                b = 8'hE0;
            else if (r == 1)
                b = 8'hF0;
            else
                b = 8'($urandom);
            send_frame(b, $urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0);
            if (n % 10 == 9) begin
                check_flags("random");
                clear_flags();
            end
        end
        drain("random");
        check_flags("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scan_fifo.md
# ps2_scan_fifo

Parametrised PS/2 keyboard receiver that replaces the ad-hoc ASCII-mapping keyboard path with a raw, validated scan-code event stream. It filters the PS/2 clock and data lines in the system `clock` domain and checks start, odd parity and stop bits. It folds the `E0` (extended) and `F0` (break) prefixes into per-event flags and buffers the events in a first-word-fall-through FIFO. A downstream mapper or the CPU's keyboard port consumes the FIFO.

## Interface
Parameters:
- `FILTER_LEN`, 16: number of consecutive identical samples required before a filtered line changes level (≥2).
- `FIFO_DEPTH`, 8: event FIFO entries; must be a power of two (≥2).
- `TIMEOUT_CYCLES`, 20000: maximum `clock` cycles allowed between PS/2 falling edges inside a frame.

Ports:
- `clock`  in  1  system clock; the block's only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk_in`  in  1  raw PS/2 clock line, asynchronous to `clock`.
- `ps2_dat_in`  in  1  raw PS/2 data line, asynchronous to `clock`.
- `rd_en`  in  1  pops the head entry when `rd_valid`=1; ignored when the FIFO is empty.
- `rd_data`  out  10  head entry {ext, brk, code[7:0]}; holds 0 when the FIFO is empty.
- `rd_valid`  out  1  FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `err_clr`  in  1  synchronous clear of the sticky error flags.
- `parity_err`  out  1  sticky: a frame was dropped for bad parity.
- `frame_err`  out  1  sticky: a frame was dropped for a bad stop bit or a timeout.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- Input conditioning:
  - Each raw line passes through a 2-flop synchroniser, then a `FILTER_LEN`-deep shift register.
  - The filtered level changes only when all `FILTER_LEN` samples agree; otherwise it holds.
  - Filtered levels reset to 1 (bus idle).
- Edge detect: `fall` pulses for one cycle when the filtered clock goes from 1 to 0. All frame sampling uses the filtered data on `fall`.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on `fall` with data=0 → DATA, bit index=0. On `fall` with data=1 → stay IDLE (no error).
  - DATA: shift the bit in LSB first. After bit 7 → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: if the stop bit is 0 → frame_err. Else if the XOR of the 8 data bits and the parity bit is 0 → parity_err. Else the byte is valid. Always → IDLE.
- Timeout: a counter clears on every `fall` and runs in any non-IDLE state. When it reaches `TIMEOUT_CYCLES`, the FSM goes to IDLE, the partial byte is discarded and frame_err is set.
- Prefix decode of valid bytes:
  - `E0` sets ext_pend.
  - `F0` sets brk_pend.
  - Any other byte, including `E1`, pushes {ext_pend, brk_pend, byte}, then clears both pends.
  - Pends reset to 0. A frame error does not clear pends.
- FIFO behaviour:
  - Push when not full.
  - Push while full with a simultaneous `rd_en` pop: the push is accepted and the count is unchanged.
  - Push while full without a pop: the event is dropped, overflow is set and the contents are unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Sticky flags:
  - Set by their event.
  - Cleared by `err_clr` on the next edge.
  - If an event and `err_clr` occur in the same cycle, the event wins and the flag stays 1.
- Reset values, effective immediately and asynchronously:
  - FSM = IDLE; counters, pends and pointers = 0.
  - `rd_data`=0, `rd_valid`=0, `fifo_count`=0, all flags=0.
  - Reset mid-frame discards the partial frame.

## Timing
- Filtered level follows a stable raw change after 2 + `FILTER_LEN` cycles. `fall` is asserted one cycle later.
- The push occurs on the `clock` edge after the `fall` of the stop bit. `rd_valid`, `fifo_count` and `rd_data` reflect it on the following cycle.
- `rd_en` with `rd_valid`=1: the next entry (or 0 if now empty) appears on `rd_data` the cycle after the pop.
- Glitches shorter than `FILTER_LEN` cycles never change the filtered levels.
- Timer width is $clog2(`TIMEOUT_CYCLES`+1). There is no wrap; the timer saturates at the timeout.

## Test plan
- Valid frame for `1C`: bits 0,0,1,1,1,0,0,0, parity 0, stop 1. Expected `rd_valid`=1, `rd_data`=10'h01C, `fifo_count`=1. Pulse `rd_en` → `rd_valid`=0, `rd_data`=0.
- Byte sequence `E0`,`F0`,`6B` → exactly one entry, `rd_data`=10'h36B. A following `1C` → 10'h01C, showing the pends were cleared.
- `1C` sent with parity 1 → no push, `parity_err`=1. Assert `err_clr` → 0. A single-cycle event coinciding with `err_clr` → flag stays 1.
- With `FIFO_DEPTH`=8, send 9 codes `01`..`09` without reads → `fifo_count`=8, `overflow`=1, head `01`. Nine pops return `01`..`08`; the pop at count 0 is ignored.
- A 3-cycle low glitch on `ps2_clk_in` (`FILTER_LEN`=16) → no bit consumed. Start bit + 4 bits, then idle `TIMEOUT_CYCLES`+1 cycles → `frame_err`=1, FSM IDLE. A next valid frame `29` → 10'h029.
- Assert `reset` mid-frame (after bit 3) → all outputs 0 at once. After release, a full `5A` frame → 10'h05A.
